// File: rtl/cursor_move_ctrl.sv
// Cursor X/Y position controller: configurable step, press-and-hold auto-repeat, clamp or wrap at canvas bounds.
// Optional acceleration (4*STEP after eight consecutive repeats) under `define CURSOR_MOVE_ACCEL_EN.
module cursor_move_ctrl #(
  parameter int X_WIDTH       = 8,
  parameter int Y_WIDTH       = 7,
  parameter int X_MAX         = 159,
  parameter int Y_MAX         = 119,
  parameter int X_INIT        = 80,
  parameter int Y_INIT        = 60,
  parameter int STEP          = 1,
  parameter int HOLD_DELAY    = 24,
  parameter int REPEAT_PERIOD = 8,
  parameter int WRAP          = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         directions,
  input  logic               load,
  input  logic [X_WIDTH-1:0] load_x,
  input  logic [Y_WIDTH-1:0] load_y,
  output logic [X_WIDTH-1:0] outX,
  output logic [Y_WIDTH-1:0] outY,
  output logic               moved,
  output logic [3:0]         at_edge
);

  localparam int XW1  = X_WIDTH + 1;
  localparam int YW1  = Y_WIDTH + 1;
  localparam int CMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [X_WIDTH-1:0] X_MAX_N = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_MAX_N = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH:0]   XMAXW   = XW1'(X_MAX);
  localparam logic [Y_WIDTH:0]   YMAXW   = YW1'(Y_MAX);
  localparam logic [X_WIDTH:0]   XMAX1   = XW1'(X_MAX + 1);
  localparam logic [Y_WIDTH:0]   YMAX1   = YW1'(Y_MAX + 1);
  localparam logic [X_WIDTH:0]   XS1     = XW1'(STEP);
  localparam logic [Y_WIDTH:0]   YS1     = YW1'(STEP);
  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0]      REP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [3:0] EDGE_INIT = {X_INIT == 0, Y_INIT == 0, X_INIT == X_MAX, Y_INIT == Y_MAX};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [3:0]         prev_dir, eff;
  logic               do_move;
  logic [X_WIDTH:0]   xw, xs, xsum;
  logic [Y_WIDTH:0]   yw, ys, ysum;
  logic [X_WIDTH-1:0] x_mv, nx;
  logic [Y_WIDTH-1:0] y_mv, ny;

  always_comb begin
    eff = directions;
    if (directions[3] && directions[1]) begin
      eff[3] = 1'b0;
      eff[1] = 1'b0;
    end
    if (directions[2] && directions[0]) begin
      eff[2] = 1'b0;
      eff[0] = 1'b0;
    end

    state_n = state;
    cnt_n   = cnt;
    do_move = 1'b0;
    case (state)
      IDLE: begin
        if (eff != '0 && eff != prev_dir) begin
          do_move = 1'b1;
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (eff == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (eff != prev_dir) begin
          do_move = 1'b1;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          do_move = 1'b1;
          state_n = REPEAT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (eff == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (eff != prev_dir) begin
          do_move = 1'b1;
          state_n = HOLD;
          cnt_n   = '0;
        end else if (cnt == REP_LAST) begin
          do_move = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (load) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_dir <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      prev_dir <= eff;
    end
  end

`ifdef CURSOR_MOVE_ACCEL_EN
  localparam logic [X_WIDTH:0] XS4 = XW1'(4 * STEP);
  localparam logic [Y_WIDTH:0] YS4 = YW1'(4 * STEP);
  logic [3:0] acc_cnt;

  // Only REPEAT-to-REPEAT period moves count; any other next state (load included) clears.
  always_ff @(posedge clock) begin
    if (reset || state_n != REPEAT)
      acc_cnt <= '0;
    else if (state == REPEAT && do_move && acc_cnt != 4'd8)
      acc_cnt <= acc_cnt + 4'd1;
  end

  assign xs = (acc_cnt == 4'd8) ? XS4 : XS1;
  assign ys = (acc_cnt == 4'd8) ? YS4 : YS1;
`else
  assign xs = XS1;
  assign ys = YS1;
`endif

  // Arithmetic is one bit wider than the position so increments never overflow before the bound test.
  always_comb begin
    xw   = {1'b0, outX};
    yw   = {1'b0, outY};
    xsum = xw + xs;
    ysum = yw + ys;

    x_mv = outX;
    if (eff[3]) begin
      if (xw < xs) x_mv = (WRAP != 0) ? X_WIDTH'(xw + (XMAX1 - xs)) : '0;
      else         x_mv = X_WIDTH'(xw - xs);
    end else if (eff[1]) begin
      if (xsum > XMAXW) x_mv = (WRAP != 0) ? X_WIDTH'(xsum - XMAX1) : X_MAX_N;
      else              x_mv = X_WIDTH'(xsum);
    end

    y_mv = outY;
    if (eff[2]) begin
      if (yw < ys) y_mv = (WRAP != 0) ? Y_WIDTH'(yw + (YMAX1 - ys)) : '0;
      else         y_mv = Y_WIDTH'(yw - ys);
    end else if (eff[0]) begin
      if (ysum > YMAXW) y_mv = (WRAP != 0) ? Y_WIDTH'(ysum - YMAX1) : Y_MAX_N;
      else              y_mv = Y_WIDTH'(ysum);
    end

    if (load) begin
      nx = (load_x > X_MAX_N) ? X_MAX_N : load_x;
      ny = (load_y > Y_MAX_N) ? Y_MAX_N : load_y;
    end else if (do_move) begin
      nx = x_mv;
      ny = y_mv;
    end else begin
      nx = outX;
      ny = outY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outX    <= X_WIDTH'(X_INIT);
      outY    <= Y_WIDTH'(Y_INIT);
      moved   <= 1'b0;
      at_edge <= EDGE_INIT;
    end else begin
      outX    <= nx;
      outY    <= ny;
      moved   <= (nx != outX) || (ny != outY);
      at_edge <= {nx == '0, ny == '0, nx == X_MAX_N, ny == Y_MAX_N};
    end
  end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl: vector table plus hold sequences, expectations queued at drive time and checked after each edge.
module tb_cursor_move_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] directions = '0;
  logic       load = 1'b0;
  logic [7:0] load_x = '0;
  logic [6:0] load_y = '0;

  logic [7:0] outX, woutX;
  logic [6:0] outY, woutY;
  logic       moved, wmoved;
  logic [3:0] at_edge, wat_edge;

`ifdef CURSOR_MOVE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  always #5 clock = ~clock;

  cursor_move_ctrl dut (
    .clock(clock), .reset(reset), .directions(directions), .load(load),
    .load_x(load_x), .load_y(load_y), .outX(outX), .outY(outY),
    .moved(moved), .at_edge(at_edge)
  );

  cursor_move_ctrl #(.WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .directions(directions), .load(load),
    .load_x(load_x), .load_y(load_y), .outX(woutX), .outY(woutY),
    .moved(wmoved), .at_edge(wat_edge)
  );

  typedef struct {
    int         id;
    logic       rst;
    logic [3:0] dir;
    logic       ld;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [7:0] x;
    logic [6:0] y;
    logic       mv;
    logic [3:0] edg;
    logic       wchk;
    logic [7:0] wx;
    logic [6:0] wy;
  } vec_t;

  vec_t sb[$];
  vec_t cur;
  vec_t tbl[26];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(int id, bit rst, bit [3:0] dir, bit ld, int lx, int ly,
                              int x, int y, bit mv, bit [3:0] edg, bit wchk, int wx, int wy);
    vec_t v;
    v.id = id; v.rst = rst; v.dir = dir; v.ld = ld; v.lx = 8'(lx); v.ly = 7'(ly);
    v.x = 8'(x); v.y = 7'(y); v.mv = mv; v.edg = edg; v.wchk = wchk; v.wx = 8'(wx); v.wy = 7'(wy);
    return v;
  endfunction

  function automatic bit [3:0] edge_of(int x, int y);
    return {x == 0, y == 0, x == 159, y == 119};
  endfunction

  // Move edges of a continuous hold started from IDLE: first press, HOLD_DELAY later, then every 8.
  function automatic bit is_move(int e);
    return (e == 0) || (e == 24) || (e >= 32 && ((e - 32) % 8) == 0);
  endfunction

  task automatic check(input int id, input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL row%0d %s got=%0d want=%0d", id, what, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clock);
    reset      = v.rst;
    directions = v.dir;
    load       = v.ld;
    load_x     = v.lx;
    load_y     = v.ly;
    sb.push_back(v);
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.id, "outX", int'(outX), int'(cur.x));
      check(cur.id, "outY", int'(outY), int'(cur.y));
      check(cur.id, "moved", int'(moved), int'(cur.mv));
      check(cur.id, "at_edge", int'(at_edge), int'(cur.edg));
      if (cur.wchk) begin
        check(cur.id, "wrap_outX", int'(woutX), int'(cur.wx));
        check(cur.id, "wrap_outY", int'(woutY), int'(cur.wy));
      end
    end
  end

  initial begin
    int ex, ey, r;
    bit mv;

    //           id rst dir     ld lx   ly    x    y  mv edge     w  wx   wy
    tbl[0]  = mk( 0, 1, 4'b0000, 0,  0,   0,  80,  60, 0, 4'b0000, 1, 80,  60);
    tbl[1]  = mk( 1, 0, 4'b0000, 0,  0,   0,  80,  60, 0, 4'b0000, 1, 80,  60);
    tbl[2]  = mk( 2, 0, 4'b1000, 0,  0,   0,  79,  60, 1, 4'b0000, 1, 79,  60);
    tbl[3]  = mk( 3, 0, 4'b0000, 0,  0,   0,  79,  60, 0, 4'b0000, 1, 79,  60);
    tbl[4]  = mk( 4, 0, 4'b0000, 0,  0,   0,  79,  60, 0, 4'b0000, 1, 79,  60);
    tbl[5]  = mk( 5, 0, 4'b0000, 1,  0,   0,   0,   0, 1, 4'b1100, 1,  0,   0);
    tbl[6]  = mk( 6, 0, 4'b1100, 0,  0,   0,   0,   0, 0, 4'b1100, 1, 159, 119);
    tbl[7]  = mk( 7, 0, 4'b1100, 0,  0,   0,   0,   0, 0, 4'b1100, 1, 159, 119);
    tbl[8]  = mk( 8, 0, 4'b0000, 0,  0,   0,   0,   0, 0, 4'b1100, 1, 159, 119);
    tbl[9]  = mk( 9, 0, 4'b0000, 1, 200, 127, 159, 119, 1, 4'b0011, 1, 159, 119);
    tbl[10] = mk(10, 0, 4'b0010, 0,  0,   0, 159, 119, 0, 4'b0011, 1,  0, 119);
    tbl[11] = mk(11, 0, 4'b0000, 0,  0,   0, 159, 119, 0, 4'b0011, 1,  0, 119);
    tbl[12] = mk(12, 0, 4'b0010, 1, 10,  10,  10,  10, 1, 4'b0000, 1, 10,  10);
    tbl[13] = mk(13, 0, 4'b0010, 0,  0,   0,  10,  10, 0, 4'b0000, 1, 10,  10);
    tbl[14] = mk(14, 0, 4'b0000, 0,  0,   0,  10,  10, 0, 4'b0000, 1, 10,  10);
    tbl[15] = mk(15, 0, 4'b1110, 0,  0,   0,  10,   9, 1, 4'b0000, 1, 10,   9);
    tbl[16] = mk(16, 0, 4'b0000, 0,  0,   0,  10,   9, 0, 4'b0000, 1, 10,   9);
    tbl[17] = mk(17, 0, 4'b0011, 0,  0,   0,  11,  10, 1, 4'b0000, 1, 11,  10);
    tbl[18] = mk(18, 0, 4'b0110, 0,  0,   0,  12,   9, 1, 4'b0000, 1, 12,   9);
    tbl[19] = mk(19, 0, 4'b0000, 0,  0,   0,  12,   9, 0, 4'b0000, 1, 12,   9);
    tbl[20] = mk(20, 0, 4'b0101, 0,  0,   0,  12,   9, 0, 4'b0000, 1, 12,   9);
    tbl[21] = mk(21, 0, 4'b0000, 1, 12,   9,  12,   9, 0, 4'b0000, 1, 12,   9);
    tbl[22] = mk(22, 0, 4'b1000, 1, 50,  50,  50,  50, 1, 4'b0000, 1, 50,  50);
    tbl[23] = mk(23, 0, 4'b0000, 0,  0,   0,  50,  50, 0, 4'b0000, 1, 50,  50);
    tbl[24] = mk(24, 1, 4'b0000, 1,  5,   5,  80,  60, 0, 4'b0000, 1, 80,  60);
    tbl[25] = mk(25, 0, 4'b0000, 0,  0,   0,  80,  60, 0, 4'b0000, 1, 80,  60);

    for (int i = 0; i < 26; i++) drive(tbl[i]);

    // Hold right for 49 edges from 80: moves at 0, 24, 32, 40, 48 -> 85.
    ex = 80;
    for (int e = 0; e < 49; e++) begin
      mv = is_move(e);
      if (mv) ex++;
      drive(mk(100 + e, 0, 4'b0010, 0, 0, 0, ex, 60, mv, edge_of(ex, 60), 1, ex, 60));
    end
    drive(mk(150, 0, 4'b0000, 0, 0, 0, 85, 60, 0, 4'b0000, 1, 85, 60));

    // Left+right cancelled with up held, then reset in the middle of REPEAT.
    ey = 60;
    for (int e = 0; e < 35; e++) begin
      mv = is_move(e);
      if (mv) ey--;
      drive(mk(200 + e, 0, 4'b1110, 0, 0, 0, 85, ey, mv, edge_of(85, ey), 1, 85, ey));
    end
    drive(mk(240, 1, 4'b1110, 0, 0, 0, 80, 60, 0, 4'b0000, 1, 80, 60));
    drive(mk(241, 0, 4'b1110, 0, 0, 0, 80, 59, 1, 4'b0000, 1, 80, 59));
    drive(mk(242, 0, 4'b0000, 0, 0, 0, 80, 59, 0, 4'b0000, 1, 80, 59));

    // Hold right from X=0 until well past the clamp at 159.
    drive(mk(300, 0, 4'b0000, 1, 0, 60, 0, 60, 1, 4'b1000, 1, 0, 60));
    ex = 0;
    r = 0;
    for (int e = 0; e < 1300; e++) begin
      int nx;
      nx = ex;
      if (is_move(e)) begin
        if (e >= 32) r++;
        nx = ex + ((ACCEL && r >= 9) ? 4 : 1);
        if (nx > 159) nx = 159;
      end
      mv = (nx != ex);
      ex = nx;
      drive(mk(1000 + e, 0, 4'b0010, 0, 0, 0, ex, 60, mv, edge_of(ex, 60), 0, 0, 0));
    end
    drive(mk(2400, 0, 4'b0000, 0, 0, 0, 159, 60, 0, 4'b0010, 0, 0, 0));

    @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
